lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller for RV32I: turns one pipeline request into one or two
// word-aligned memory beats, assembles and extends load data, and returns one response.
module lsu_ctrl #(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int MEM_WIDTH        = 32   // only 32 is supported
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [31:0]          i_req_addr,
    input  logic                 i_req_wen,
    input  logic [2:0]           i_req_funct3,
    input  logic [MEM_WIDTH-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [MEM_WIDTH-1:0] o_rsp_rdata,
    output logic                 o_rsp_trap,
    output logic                 o_mem_req,
    input  logic                 i_mem_ready,
    output logic [31:0]          o_mem_addr,
    output logic                 o_mem_ren,
    output logic                 o_mem_wen,
    output logic [3:0]           o_mem_mask,
    output logic [MEM_WIDTH-1:0] o_mem_wdata,
    input  logic                 i_mem_valid,
    input  logic [MEM_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic [31:0] beat0_q, beat0_d;
    logic [31:0] rdata_q, rdata_d;
    logic        trap_q, trap_d;

    // Decode of the request presented at the input, used on acceptance.
    logic [1:0] req_off;
    logic       req_legal, req_mis, req_trap;

    always_comb begin
        req_off   = i_req_addr[1:0];
        req_legal = i_req_wen ? (i_req_funct3 inside {3'd0, 3'd1, 3'd2})
                              : (i_req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        req_mis   = ((i_req_funct3[1:0] == 2'd1) && (req_off == 2'd3)) ||
                    ((i_req_funct3[1:0] == 2'd2) && (req_off != 2'd0));
        req_trap  = !req_legal || (req_mis && (SPLIT_MISALIGNED == 0));
    end

    // Lane placement of the latched access; the upper half of each wide vector is beat 1.
    logic [1:0]  off_q;
    logic [3:0]  base_mask;
    logic [7:0]  mask_wide;
    logic [63:0] wdata_wide;
    logic [31:0] word_addr;
    logic [5:0]  beat1_shamt;
    logic [31:0] beat0_shift, beat1_merge;

    always_comb begin
        off_q = addr_q[1:0];
        case (funct3_q[1:0])
            2'd0:    base_mask = 4'b0001;
            2'd1:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask_wide   = {4'b0000, base_mask} << off_q;
        wdata_wide  = {32'd0, wdata_q} << {off_q, 3'b000};
        word_addr   = {addr_q[31:2], 2'b00};
        beat1_shamt = 6'd32 - {1'b0, off_q, 3'b000};
        beat0_shift = i_mem_rdata >> {off_q, 3'b000};
        beat1_merge = beat0_q | (i_mem_rdata << beat1_shamt);
    end

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        split_d  = split_q;
        beat0_d  = beat0_q;
        rdata_d  = rdata_q;
        trap_d   = trap_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d   = i_req_addr;
                    wen_d    = i_req_wen;
                    funct3_d = i_req_funct3;
                    wdata_d  = i_req_wdata;
                    split_d  = req_mis;
                    trap_d   = req_trap;
                    rdata_d  = 32'd0;
                    state_d  = req_trap ? S_RESP : S_REQ0;
                end
            end
            S_REQ0: if (i_mem_ready) state_d = S_WAIT0;
            S_WAIT0: begin
                if (i_mem_valid) begin
                    if (split_q) begin
                        beat0_d = beat0_shift;
                        state_d = S_REQ1;
                    end else begin
                        rdata_d = wen_q ? 32'd0 : extend(funct3_q, beat0_shift);
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ1: if (i_mem_ready) state_d = S_WAIT1;
            S_WAIT1: begin
                if (i_mem_valid) begin
                    rdata_d = wen_q ? 32'd0 : extend(funct3_q, beat1_merge);
                    state_d = S_RESP;
                end
            end
            S_RESP: if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            split_q  <= 1'b0;
            beat0_q  <= 32'd0;
            rdata_q  <= 32'd0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            beat0_q  <= beat0_d;
            rdata_q  <= rdata_d;
            trap_q   <= trap_d;
        end
    end

    // Outputs are forced low while reset is held, whatever state the register still shows.
    logic in_req0, in_req1, in_resp;

    always_comb begin
        in_req0     = (state_q == S_REQ0) && !i_rst;
        in_req1     = (state_q == S_REQ1) && !i_rst;
        in_resp     = (state_q == S_RESP) && !i_rst;
        o_req_ready = (state_q == S_IDLE) && !i_rst;
        o_mem_req   = in_req0 || in_req1;
        o_mem_ren   = o_mem_req && !wen_q;
        o_mem_wen   = o_mem_req && wen_q;
        o_mem_addr  = 32'd0;
        o_mem_mask  = 4'd0;
        o_mem_wdata = 32'd0;
        if (in_req0) begin
            o_mem_addr  = word_addr;
            o_mem_mask  = mask_wide[3:0];
            o_mem_wdata = wdata_wide[31:0];
        end else if (in_req1) begin
            o_mem_addr  = word_addr + 32'd4;
            o_mem_mask  = mask_wide[7:4];
            o_mem_wdata = wdata_wide[63:32];
        end
        o_rsp_valid = in_resp;
        o_rsp_trap  = in_resp && trap_q;
        o_rsp_rdata = in_resp ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned, narrow, split, wrapping, trapping and
// reset-abandoned accesses, with a hand-written expected value for every check.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid_b = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0, rsp_ready_b = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_ready, rsp_valid, rsp_trap, mem_req, mem_ren, mem_wen;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    logic        req_ready_b, rsp_valid_b, rsp_trap_b, mem_req_b, mem_ren_b, mem_wen_b;
    logic [31:0] rsp_rdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_mask_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.SPLIT_MISALIGNED(1), .MEM_WIDTH(32)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .i_req_wen(req_wen), .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_trap(rsp_trap), .o_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
        .o_mem_mask(mem_mask), .o_mem_wdata(mem_wdata), .i_mem_valid(mem_valid),
        .i_mem_rdata(mem_rdata)
    );

    // Trapping variant; shares the request fields but has its own valid/ready.
    lsu_ctrl #(.SPLIT_MISALIGNED(0), .MEM_WIDTH(32)) u_dut_nosplit (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid_b), .o_req_ready(req_ready_b), .i_req_addr(req_addr),
        .i_req_wen(req_wen), .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready_b), .o_rsp_rdata(rsp_rdata_b),
        .o_rsp_trap(rsp_trap_b), .o_mem_req(mem_req_b), .i_mem_ready(mem_ready),
        .o_mem_addr(mem_addr_b), .o_mem_ren(mem_ren_b), .o_mem_wen(mem_wen_b),
        .o_mem_mask(mem_mask_b), .o_mem_wdata(mem_wdata_b), .i_mem_valid(mem_valid),
        .i_mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic wen,
                            input logic [2:0] f3, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", {31'd0, req_ready}, 32'd1);
        req_addr   = addr;
        req_wen    = wen;
        req_funct3 = f3;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        $display("req addr=%08h wen=%0d funct3=%0d wdata=%08h", addr, wen, f3, wdata);
    endtask

    // One memory beat: check the presented beat, stall it, accept it, then complete it.
    task automatic do_beat(input string tag, input logic [31:0] eaddr, input logic [3:0] emask,
                           input logic ewen, input logic [31:0] ewdata,
                           input logic [31:0] rdata, input int stall);
        int n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"}, mem_addr, eaddr);
        check({tag, "_mask"}, {28'd0, mem_mask}, {28'd0, emask});
        check({tag, "_strobes"}, {30'd0, mem_ren, mem_wen}, {30'd0, !ewen, ewen});
        if (ewen) check({tag, "_wdata"}, mem_wdata, ewdata);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_addr"}, mem_addr, eaddr);
            check({tag, "_stall_mask"}, {27'd0, mem_req, mem_mask}, {27'd0, 1'b1, emask});
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check({tag, "_wait_noreq"}, {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rdata = rdata;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        mem_rdata = 32'hA5A5A5A5;
        $display("beat %s addr=%08h mask=%h wdata=%08h rdata=%08h", tag, eaddr, emask, ewdata, rdata);
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] erdata, input logic etrap,
                           input int hold);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_rdata"}, rsp_rdata, erdata);
        check({tag, "_rsp_trap"}, {31'd0, rsp_trap}, {31'd0, etrap});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {rsp_rdata[30:0], rsp_trap}, {erdata[30:0], etrap});
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_back_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
        $display("rsp %s rdata=%08h trap=%0d", tag, erdata, etrap);
    endtask

    initial begin
        // Reset: outputs quiet while held, ready the cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {24'd0, mem_req, mem_ren, mem_wen, rsp_valid, rsp_trap, 3'd0}, 32'd0);
        check("rst_mask", {28'd0, mem_mask}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        send_req(32'h0000_0100, 1'b0, 3'd2, 32'd0);
        do_beat("lw", 32'h0000_0100, 4'b1111, 1'b0, 32'd0, 32'hDEAD_BEEF, 0);
        get_rsp("lw", 32'hDEAD_BEEF, 1'b0, 0);

        send_req(32'h0000_0203, 1'b0, 3'd0, 32'd0);
        do_beat("lb", 32'h0000_0200, 4'b1000, 1'b0, 32'd0, 32'h8012_3456, 1);
        get_rsp("lb", 32'hFFFF_FF80, 1'b0, 0);

        send_req(32'h0000_0203, 1'b0, 3'd4, 32'd0);
        do_beat("lbu", 32'h0000_0200, 4'b1000, 1'b0, 32'd0, 32'h8012_3456, 0);
        get_rsp("lbu", 32'h0000_0080, 1'b0, 0);

        send_req(32'h0000_0102, 1'b1, 3'd2, 32'hAABB_CCDD);
        do_beat("sw_b0", 32'h0000_0100, 4'b1100, 1'b1, 32'hCCDD_0000, 32'd0, 2);
        do_beat("sw_b1", 32'h0000_0104, 4'b0011, 1'b1, 32'h0000_AABB, 32'd0, 0);
        get_rsp("sw", 32'd0, 1'b0, 0);

        send_req(32'hFFFF_FFFF, 1'b0, 3'd1, 32'd0);
        do_beat("lh_b0", 32'hFFFF_FFFC, 4'b1000, 1'b0, 32'd0, 32'h12AA_BBCC, 0);
        do_beat("lh_b1", 32'h0000_0000, 4'b0001, 1'b0, 32'd0, 32'hDDEE_FF34, 0);
        get_rsp("lh_wrap", 32'h0000_3412, 1'b0, 0);

        send_req(32'h0000_0402, 1'b0, 3'd1, 32'd0);
        do_beat("lh_hi", 32'h0000_0400, 4'b1100, 1'b0, 32'd0, 32'h8001_7777, 0);
        get_rsp("lh_hi", 32'hFFFF_8001, 1'b0, 0);

        send_req(32'h0000_0201, 1'b1, 3'd1, 32'h1234_BEEF);
        do_beat("sh", 32'h0000_0200, 4'b0110, 1'b1, 32'h34BE_EF00, 32'd0, 0);
        get_rsp("sh", 32'd0, 1'b0, 0);

        // Illegal load funct3: straight to a trap response, held while not accepted.
        send_req(32'h0000_0100, 1'b0, 3'd3, 32'd0);
        @(negedge clk);
        check("f3_noreq", {31'd0, mem_req}, 32'd0);
        get_rsp("f3_trap", 32'd0, 1'b1, 5);

        send_req(32'h0000_0100, 1'b1, 3'd4, 32'h1111_1111);
        get_rsp("st_f3_trap", 32'd0, 1'b1, 0);

        // Misaligned word on the non-splitting instance.
        @(negedge clk);
        req_addr    = 32'h0000_0101;
        req_wen     = 1'b0;
        req_funct3  = 3'd2;
        req_valid_b = 1'b1;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mis_noreq", {31'd0, mem_req_b}, 32'd0);
            check("mis_rsp", {29'd0, rsp_valid_b, rsp_trap_b, req_ready_b}, 32'd6);
            check("mis_rdata", rsp_rdata_b, 32'd0);
        end
        rsp_ready_b = 1'b1;
        @(posedge clk);
        #1 rsp_ready_b = 1'b0;
        @(negedge clk);
        check("mis_idle", {30'd0, req_ready_b, rsp_valid_b}, 32'd2);
        $display("rsp mis_trap addr=00000101 trap=1");

        // Reset while waiting for beat 0, then a late completion.
        send_req(32'h0000_0300, 1'b0, 3'd2, 32'd0);
        @(negedge clk);
        check("abort_req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort_rst_out", {29'd0, mem_req, rsp_valid, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_idle", {29'd0, req_ready, rsp_valid, mem_req}, 32'd4);
        end
        $display("abort addr=00000300 late_valid ignored");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
